// File: rtl/fft_frame_loader.sv
// fft_frame_loader: gathers a stream of complex Q8.8 samples into an N-entry
// frame, zero-pads short frames, holds the frame for a settle window so the
// downstream combinational FFT can resolve, then hands the frame off.
module fft_frame_loader #(
  parameter int unsigned N             = 16,
  parameter int unsigned W             = 16,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_re,
  input  logic [W-1:0]   in_im,
  input  logic           in_last,
  output logic [N*W-1:0] frame_re,
  output logic [N*W-1:0] frame_im,
  output logic           frame_valid,
  input  logic           frame_ready,
  output logic           frame_short,
  output logic [15:0]    frame_count
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned FW = N * W;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [7:0] SETTLE_LAST =
    (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_PAD    = 2'd1,
    S_SETTLE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [FW-1:0]   frame_re_q, frame_re_d;
  logic [FW-1:0]   frame_im_q, frame_im_d;
  logic            frame_short_q, frame_short_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic            in_ready_q, in_ready_d;
  logic            frame_valid_q, frame_valid_d;

  // Next-state, frame storage and handshake flag computation.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    frame_re_d    = frame_re_q;
    frame_im_d    = frame_im_q;
    frame_short_d = frame_short_q;
    frame_count_d = frame_count_q;

    case (state_q)
      S_FILL: begin
        // in_ready is high throughout FILL, so in_valid alone means accept.
        if (in_valid) begin
          for (int unsigned k = 0; k < N; k++) begin
            if (IW'(k) == idx_q) begin
              frame_re_d[k*W +: W] = in_re;
              frame_im_d[k*W +: W] = in_im;
            end
          end
          idx_d = idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
            frame_short_d = 1'b0;
            cnt_d         = 8'd0;
            state_d       = (SETTLE_CYCLES == 0) ? S_HOLD : S_SETTLE;
          end else if (in_last) begin
            state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        // idx_q holds the number of written entries; clear everything above.
        for (int unsigned k = 0; k < N; k++) begin
          if (IW'(k) >= idx_q) begin
            frame_re_d[k*W +: W] = '0;
            frame_im_d[k*W +: W] = '0;
          end
        end
        frame_short_d = 1'b1;
        cnt_d         = 8'd0;
        state_d       = (SETTLE_CYCLES == 0) ? S_HOLD : S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (frame_ready) begin
          state_d       = S_FILL;
          idx_d         = '0;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase

    in_ready_d    = (state_d == S_FILL);
    frame_valid_d = (state_d == S_HOLD);
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FILL;
      idx_q         <= '0;
      cnt_q         <= 8'd0;
      frame_re_q    <= '0;
      frame_im_q    <= '0;
      frame_short_q <= 1'b0;
      frame_count_q <= 16'd0;
      in_ready_q    <= 1'b1;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      frame_re_q    <= frame_re_d;
      frame_im_q    <= frame_im_d;
      frame_short_q <= frame_short_d;
      frame_count_q <= frame_count_d;
      in_ready_q    <= in_ready_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign frame_valid = frame_valid_q;
  assign frame_re    = frame_re_q;
  assign frame_im    = frame_im_q;
  assign frame_short = frame_short_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Testbench for fft_frame_loader: two instances (settle 2 and settle 0),
// scoreboard of expected frames, directed steps in one initial block.
module tb_fft_frame_loader;

  localparam int unsigned N  = 16;
  localparam int unsigned W  = 16;
  localparam int unsigned FW = N * W;

  typedef struct packed {
    logic [FW-1:0] re;
    logic [FW-1:0] im;
    logic          short_f;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in_re = '0;
  logic [W-1:0]  in_im = '0;
  logic          in_valid    [2];
  logic          in_last     [2];
  logic          frame_ready [2];
  logic          in_ready    [2];
  logic          frame_valid [2];
  logic          frame_short [2];
  logic [FW-1:0] frame_re    [2];
  logic [FW-1:0] frame_im    [2];
  logic [15:0]   frame_count [2];

  exp_t          sb[$];
  exp_t          last_exp;
  logic [15:0]   exp_cnt [2];
  logic [W-1:0]  re_a [16];
  logic [W-1:0]  im_a [16];
  int            tests = 0;
  int            fails = 0;
  int            cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fft_frame_loader #(.N(N), .W(W), .SETTLE_CYCLES(2)) u_dut_s2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_re(in_re), .in_im(in_im), .in_last(in_last[0]),
    .frame_re(frame_re[0]), .frame_im(frame_im[0]),
    .frame_valid(frame_valid[0]), .frame_ready(frame_ready[0]),
    .frame_short(frame_short[0]), .frame_count(frame_count[0])
  );

  fft_frame_loader #(.N(N), .W(W), .SETTLE_CYCLES(0)) u_dut_s0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_re(in_re), .in_im(in_im), .in_last(in_last[1]),
    .frame_re(frame_re[1]), .frame_im(frame_im[1]),
    .frame_valid(frame_valid[1]), .frame_ready(frame_ready[1]),
    .frame_short(frame_short[1]), .frame_count(frame_count[1])
  );

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    check(tag, FW'(obs), FW'(exp));
  endtask

  // Present one sample and wait (bounded) for it to be taken; ends on a negedge.
  task automatic push(input int d, input logic [W-1:0] re, input logic [W-1:0] im,
                      input logic last, output int acc);
    int n = 0;
    in_re       = re;
    in_im       = im;
    in_last[d]  = last;
    in_valid[d] = 1'b1;
    while (!in_ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_i("accept_bound", int'(n < 100), 1);
    @(posedge clk);
    @(negedge clk);
    acc         = cyc;
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
  endtask

  // Queue the expected frame, then stream len samples.
  task automatic send_frame(input int d, input logic [W-1:0] ra [16], input logic [W-1:0] ia [16],
                            input int len, input logic mark_last,
                            output int first_acc, output int last_acc);
    exp_t e;
    e.re      = '0;
    e.im      = '0;
    e.short_f = (len < int'(N));
    for (int i = 0; i < len; i++) begin
      e.re[i*W +: W] = ra[i];
      e.im[i*W +: W] = ia[i];
    end
    sb.push_back(e);
    first_acc = 0;
    last_acc  = 0;
    for (int i = 0; i < len; i++) begin
      int a;
      push(d, ra[i], ia[i], mark_last && (i == len - 1), a);
      if (i == 0) first_acc = a;
      last_acc = a;
    end
  endtask

  // Wait for frame_valid, check latency and frame contents against the scoreboard.
  task automatic wait_valid(input int d, input int last_acc, input int exp_delay);
    int n = 0;
    while (!frame_valid[d] && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_i("valid_bound", int'(n < 60), 1);
    check_i("valid_latency", cyc - last_acc, exp_delay);
    check_i("sb_nonempty", int'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      last_exp = sb.pop_front();
      check("frame_re", frame_re[d], last_exp.re);
      check("frame_im", frame_im[d], last_exp.im);
      check_i("frame_short", int'(frame_short[d]), int'(last_exp.short_f));
      check_i("in_ready_hold", int'(in_ready[d]), 0);
    end
  endtask

  // Complete the frame handshake and check the return to FILL.
  task automatic handshake(input int d, output int hs);
    frame_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hs             = cyc;
    frame_ready[d] = 1'b0;
    exp_cnt[d]     = exp_cnt[d] + 16'd1;
    check_i("valid_drop", int'(frame_valid[d]), 0);
    check_i("ready_back", int'(in_ready[d]), 1);
    check_i("frame_count", int'(frame_count[d]), int'(exp_cnt[d]));
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 16; k++) begin
      re_a[k] = 16'($urandom);
      im_a[k] = 16'($urandom);
    end
  endtask

  initial begin
    int fa, la, hs, a;
    logic [W-1:0] nre [16];
    logic [W-1:0] nim [16];
    for (int d = 0; d < 2; d++) begin
      in_valid[d]    = 1'b0;
      in_last[d]     = 1'b0;
      frame_ready[d] = 1'b0;
      exp_cnt[d]     = 16'd0;
    end

    // Reset defaults
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_i("rst_in_ready", int'(in_ready[d]), 1);
      check_i("rst_valid", int'(frame_valid[d]), 0);
      check_i("rst_count", int'(frame_count[d]), 0);
      check_i("rst_short", int'(frame_short[d]), 0);
      check("rst_re", frame_re[d], '0);
      check("rst_im", frame_im[d], '0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Full frame, frame_ready already high before HOLD
    frame_ready[0] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      re_a[k] = 16'(k << 8);
      im_a[k] = 16'((15 - k) << 8);
    end
    send_frame(0, re_a, im_a, 16, 1'b0, fa, la);
    wait_valid(0, la, 2);
    handshake(0, hs);

    // Short frame, zero padded
    re_a[0] = 16'h0100; im_a[0] = 16'h0000;
    re_a[1] = 16'h0000; im_a[1] = 16'hFF00;
    re_a[2] = 16'hFF00; im_a[2] = 16'h0000;
    re_a[3] = 16'h0000; im_a[3] = 16'h0100;
    send_frame(0, re_a, im_a, 4, 1'b1, fa, la);
    wait_valid(0, la, 3);
    handshake(0, hs);

    // Back-pressure: frame held 20 cycles with the next sample pending
    rand_frame();
    send_frame(0, re_a, im_a, 16, 1'b1, fa, la);
    wait_valid(0, la, 2);
    for (int k = 0; k < 16; k++) begin
      nre[k] = 16'($urandom);
      nim[k] = 16'($urandom);
    end
    in_re       = nre[0];
    in_im       = nim[0];
    in_valid[0] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check_i("bp_in_ready", int'(in_ready[0]), 0);
      check_i("bp_valid", int'(frame_valid[0]), 1);
      check("bp_re", frame_re[0], last_exp.re);
      check("bp_im", frame_im[0], last_exp.im);
    end
    handshake(0, hs);
    send_frame(0, nre, nim, 16, 1'b0, fa, la);
    check_i("bp_first_accept", fa, hs + 1);
    wait_valid(0, la, 2);
    handshake(0, hs);

    // Reset mid-fill
    rand_frame();
    for (int k = 0; k < 7; k++) push(0, re_a[k], im_a[k], 1'b0, a);
    rst = 1'b1;
    #1;
    check_i("mid_rst_in_ready", int'(in_ready[0]), 1);
    check_i("mid_rst_valid", int'(frame_valid[0]), 0);
    check_i("mid_rst_count", int'(frame_count[0]), 0);
    check("mid_rst_re", frame_re[0], '0);
    check("mid_rst_im", frame_im[0], '0);
    @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    exp_cnt[0] = 16'd0;
    exp_cnt[1] = 16'd0;
    @(negedge clk);
    rand_frame();
    send_frame(0, re_a, im_a, 16, 1'b0, fa, la);
    wait_valid(0, la, 2);
    handshake(0, hs);

    // Zero settle cycles and frame_count wrap
    force u_dut_s0.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release u_dut_s0.frame_count_q;
    @(negedge clk);
    exp_cnt[1] = 16'hFFFF;
    check_i("preload_count", int'(frame_count[1]), int'(exp_cnt[1]));
    rand_frame();
    send_frame(1, re_a, im_a, 16, 1'b0, fa, la);
    wait_valid(1, la, 0);
    handshake(1, hs);
    rand_frame();
    send_frame(1, re_a, im_a, 5, 1'b1, fa, la);
    wait_valid(1, la, 1);
    handshake(1, hs);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "time limit");
  end

endmodule
